// File: rtl/alu_op_sequencer_if.sv
// Command / ALU-datapath / result bundle for the 4-bit ALU issue sequencer.
// The slave modport is the sequencer's view; master is the host + ALU side.
interface alu_op_sequencer_if #(
  parameter int CNT_W = 8
);
  logic             Cmd_Valid;
  logic             Cmd_Ready;
  logic [3:0]       Cmd_Opcode;
  logic [3:0]       Cmd_A;
  logic [3:0]       Cmd_B;
  logic [3:0]       ALU_Sel;
  logic [3:0]       ALU_A;
  logic [3:0]       ALU_B;
  logic [3:0]       ALU_Out;
  logic             Res_Valid;
  logic             Res_Ready;
  logic [3:0]       Res_Data;
  logic [3:0]       Res_Opcode;
  logic             Res_Zero;
  logic [CNT_W-1:0] Op_Count;

  modport slave (
    input  Cmd_Valid, Cmd_Opcode, Cmd_A, Cmd_B, ALU_Out, Res_Ready,
    output Cmd_Ready, ALU_Sel, ALU_A, ALU_B,
           Res_Valid, Res_Data, Res_Opcode, Res_Zero, Op_Count
  );

  modport master (
    output Cmd_Valid, Cmd_Opcode, Cmd_A, Cmd_B, ALU_Out, Res_Ready,
    input  Cmd_Ready, ALU_Sel, ALU_A, ALU_B,
           Res_Valid, Res_Data, Res_Opcode, Res_Zero, Op_Count
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Issues one ALU command at a time, waits for the result to settle, returns it.
//   state  | meaning
//   S_IDLE | Cmd_Ready high, waiting for a command
//   S_WAIT | operands driven to the ALU, settle counter running down
//   S_RESP | result captured, Res_Valid high until the consumer takes it
module alu_op_sequencer #(
  parameter int SETTLE_CYCLES = 1,
  parameter int CNT_W         = 8
) (
  input  logic               clk,
  input  logic               rst,
  alu_op_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES - 1);

  state_t           state_q, state_d;
  logic             cmd_ready_q, cmd_ready_d;
  logic [3:0]       alu_sel_q, alu_sel_d;
  logic [3:0]       alu_a_q, alu_a_d;
  logic [3:0]       alu_b_q, alu_b_d;
  logic [3:0]       settle_q, settle_d;
  logic             res_valid_q, res_valid_d;
  logic [3:0]       res_data_q, res_data_d;
  logic [3:0]       res_opcode_q, res_opcode_d;
  logic             res_zero_q, res_zero_d;
  logic [CNT_W-1:0] op_count_q, op_count_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cmd_ready_q  <= 1'b0;
      alu_sel_q    <= 4'b0000;
      alu_a_q      <= 4'b0000;
      alu_b_q      <= 4'b0000;
      settle_q     <= 4'b0000;
      res_valid_q  <= 1'b0;
      res_data_q   <= 4'b0000;
      res_opcode_q <= 4'b0000;
      res_zero_q   <= 1'b0;
      op_count_q   <= '0;
    end else begin
      state_q      <= state_d;
      cmd_ready_q  <= cmd_ready_d;
      alu_sel_q    <= alu_sel_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      settle_q     <= settle_d;
      res_valid_q  <= res_valid_d;
      res_data_q   <= res_data_d;
      res_opcode_q <= res_opcode_d;
      res_zero_q   <= res_zero_d;
      op_count_q   <= op_count_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    alu_sel_d    = alu_sel_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    settle_d     = settle_q;
    res_valid_d  = res_valid_q;
    res_data_d   = res_data_q;
    res_opcode_d = res_opcode_q;
    res_zero_d   = res_zero_q;
    op_count_d   = op_count_q;

    case (state_q)
      S_IDLE: begin
        if (bus.Cmd_Valid && cmd_ready_q) begin
          alu_sel_d    = bus.Cmd_Opcode;
          alu_a_d      = bus.Cmd_A;
          alu_b_d      = bus.Cmd_B;
          res_opcode_d = bus.Cmd_Opcode;
          settle_d     = SETTLE_INIT;
          state_d      = S_WAIT;
        end
      end
      S_WAIT: begin
        if (settle_q == 4'd0) begin
          res_data_d  = bus.ALU_Out;
          res_zero_d  = (bus.ALU_Out == 4'b0000);
          res_valid_d = 1'b1;
          state_d     = S_RESP;
        end else begin
          settle_d = settle_q - 4'd1;
        end
      end
      S_RESP: begin
        if (res_valid_q && bus.Res_Ready) begin
          res_valid_d = 1'b0;
          op_count_d  = op_count_q + CNT_W'(1);
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Ready is registered, so it tracks where the FSM is headed next cycle.
    cmd_ready_d = (state_d == S_IDLE);
  end

  assign bus.Cmd_Ready  = cmd_ready_q;
  assign bus.ALU_Sel    = alu_sel_q;
  assign bus.ALU_A      = alu_a_q;
  assign bus.ALU_B      = alu_b_q;
  assign bus.Res_Valid  = res_valid_q;
  assign bus.Res_Data   = res_data_q;
  assign bus.Res_Opcode = res_opcode_q;
  assign bus.Res_Zero   = res_zero_q;
  assign bus.Op_Count   = op_count_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench: three sequencer instances (settle 1, settle 4, 2-bit counter)
// each driving a behavioural 4-bit ALU.
module tb_alu_op_sequencer;

  logic clk;
  logic rst;
  int   vec_cnt;
  int   err_cnt;
  logic [7:0] exp_cnt1;

  alu_op_sequencer_if #(.CNT_W(8)) if1 ();
  alu_op_sequencer_if #(.CNT_W(8)) if4 ();
  alu_op_sequencer_if #(.CNT_W(2)) ifw ();

  alu_op_sequencer #(.SETTLE_CYCLES(1), .CNT_W(8)) dut1 (.clk(clk), .rst(rst), .bus(if1));
  alu_op_sequencer #(.SETTLE_CYCLES(4), .CNT_W(8)) dut4 (.clk(clk), .rst(rst), .bus(if4));
  alu_op_sequencer #(.SETTLE_CYCLES(1), .CNT_W(2)) dutw (.clk(clk), .rst(rst), .bus(ifw));

  function automatic logic [3:0] alu_f(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
    case (op)
      4'h0: return a + b;
      4'h1: return a - b;
      4'h2: return a + 4'd1;
      4'h3: return a - 4'd1;
      4'h4: return {a[2:0], 1'b0};
      4'h5: return {1'b0, a[3:1]};
      4'h6: return {a[2:0], a[3]};
      4'h7: return {a[0], a[3:1]};
      4'h8: return a & b;
      4'h9: return a | b;
      4'hA: return a ^ b;
      4'hB: return ~(a | b);
      4'hC: return ~(a & b);
      4'hD: return ~(a ^ b);
      4'hE: return (a > b) ? 4'd1 : 4'd0;
      default: return (a == b) ? 4'd1 : 4'd0;
    endcase
  endfunction

  assign if1.ALU_Out = alu_f(if1.ALU_Sel, if1.ALU_A, if1.ALU_B);
  assign if4.ALU_Out = alu_f(if4.ALU_Sel, if4.ALU_A, if4.ALU_B);
  assign ifw.ALU_Out = alu_f(ifw.ALU_Sel, ifw.ALU_A, ifw.ALU_B);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_ready1();
    int n;
    n = 0;
    while (if1.Cmd_Ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_ready_wait", {31'd0, if1.Cmd_Ready}, 32'd1);
  endtask

  // Full no-backpressure transaction on the settle-1 instance with exact latency.
  task automatic do_op1(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] exp_d, input logic exp_z);
    wait_ready1();
    if1.Cmd_Valid  = 1'b1;
    if1.Cmd_Opcode = op;
    if1.Cmd_A      = a;
    if1.Cmd_B      = b;
    if1.Res_Ready  = 1'b1;
    @(negedge clk);
    if1.Cmd_Valid  = 1'b0;
    chk("accept_cmd_ready", {31'd0, if1.Cmd_Ready}, 32'd0);
    chk("accept_alu_sel", {28'd0, if1.ALU_Sel}, {28'd0, op});
    chk("accept_alu_a", {28'd0, if1.ALU_A}, {28'd0, a});
    chk("accept_alu_b", {28'd0, if1.ALU_B}, {28'd0, b});
    chk("accept_res_valid", {31'd0, if1.Res_Valid}, 32'd0);
    @(negedge clk);
    chk("res_valid", {31'd0, if1.Res_Valid}, 32'd1);
    chk("res_data", {28'd0, if1.Res_Data}, {28'd0, exp_d});
    chk("res_zero", {31'd0, if1.Res_Zero}, {31'd0, exp_z});
    chk("res_opcode", {28'd0, if1.Res_Opcode}, {28'd0, op});
    @(negedge clk);
    exp_cnt1 = exp_cnt1 + 8'd1;
    chk("done_res_valid", {31'd0, if1.Res_Valid}, 32'd0);
    chk("done_cmd_ready", {31'd0, if1.Cmd_Ready}, 32'd1);
    chk("op_count", {24'd0, if1.Op_Count}, {24'd0, exp_cnt1});
  endtask

  typedef struct {
    logic [3:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] data;
    logic       zero;
  } vec_t;

  vec_t vt[19];
  logic [1:0] wrap_exp[5];

  initial begin
    vt[0]  = '{4'h0, 4'h3, 4'h5, 4'h8, 1'b0};
    vt[1]  = '{4'h1, 4'h5, 4'h5, 4'h0, 1'b1};
    vt[2]  = '{4'h2, 4'hF, 4'h0, 4'h0, 1'b1};
    vt[3]  = '{4'h0, 4'hF, 4'h1, 4'h0, 1'b1};
    vt[4]  = '{4'h8, 4'hC, 4'hA, 4'h8, 1'b0};
    vt[5]  = '{4'h9, 4'h5, 4'hA, 4'hF, 1'b0};
    vt[6]  = '{4'hA, 4'hF, 4'hF, 4'h0, 1'b1};
    vt[7]  = '{4'hF, 4'h7, 4'h7, 4'h1, 1'b0};
    vt[8]  = '{4'hF, 4'h7, 4'h6, 4'h0, 1'b1};
    vt[9]  = '{4'hE, 4'h9, 4'h3, 4'h1, 1'b0};
    vt[10] = '{4'h4, 4'h9, 4'h0, 4'h2, 1'b0};
    vt[11] = '{4'h5, 4'h9, 4'h0, 4'h4, 1'b0};
    vt[12] = '{4'h6, 4'h9, 4'h0, 4'h3, 1'b0};
    vt[13] = '{4'h7, 4'h9, 4'h0, 4'hC, 1'b0};
    vt[14] = '{4'hB, 4'h5, 4'hA, 4'h0, 1'b1};
    vt[15] = '{4'hC, 4'hC, 4'hA, 4'h7, 1'b0};
    vt[16] = '{4'hD, 4'h5, 4'h5, 4'hF, 1'b0};
    vt[17] = '{4'h3, 4'h0, 4'h0, 4'hF, 1'b0};
    vt[18] = '{4'h1, 4'h3, 4'h5, 4'hE, 1'b0};
    wrap_exp[0] = 2'd1; wrap_exp[1] = 2'd2; wrap_exp[2] = 2'd3;
    wrap_exp[3] = 2'd0; wrap_exp[4] = 2'd1;

    vec_cnt  = 0;
    err_cnt  = 0;
    exp_cnt1 = 8'd0;
    rst = 1'b1;
    if1.Cmd_Valid = 1'b0; if1.Cmd_Opcode = 4'h0; if1.Cmd_A = 4'h0; if1.Cmd_B = 4'h0; if1.Res_Ready = 1'b1;
    if4.Cmd_Valid = 1'b0; if4.Cmd_Opcode = 4'h0; if4.Cmd_A = 4'h0; if4.Cmd_B = 4'h0; if4.Res_Ready = 1'b1;
    ifw.Cmd_Valid = 1'b0; ifw.Cmd_Opcode = 4'h0; ifw.Cmd_A = 4'h0; ifw.Cmd_B = 4'h0; ifw.Res_Ready = 1'b1;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", {31'd0, if1.Cmd_Ready}, 32'd0);
    chk("rst_res_valid", {31'd0, if1.Res_Valid}, 32'd0);
    chk("rst_alu_sel", {28'd0, if1.ALU_Sel}, 32'd0);
    chk("rst_res_data", {28'd0, if1.Res_Data}, 32'd0);
    chk("rst_res_zero", {31'd0, if1.Res_Zero}, 32'd0);
    chk("rst_op_count", {24'd0, if1.Op_Count}, 32'd0);
    rst = 1'b0;
    #1;
    chk("release_cmd_ready_low", {31'd0, if1.Cmd_Ready}, 32'd0);
    @(negedge clk);
    chk("release_cmd_ready_1", {31'd0, if1.Cmd_Ready}, 32'd1);
    chk("release_cmd_ready_4", {31'd0, if4.Cmd_Ready}, 32'd1);
    chk("release_cmd_ready_w", {31'd0, ifw.Cmd_Ready}, 32'd1);

    // Opcode table, no backpressure
    for (int i = 0; i < 19; i++)
      do_op1(vt[i].op, vt[i].a, vt[i].b, vt[i].data, vt[i].zero);

    // Backpressure: result held, ready low, stray command pulses ignored
    wait_ready1();
    if1.Res_Ready  = 1'b0;
    if1.Cmd_Valid  = 1'b1;
    if1.Cmd_Opcode = 4'h8; if1.Cmd_A = 4'hC; if1.Cmd_B = 4'hA;
    @(negedge clk);
    if1.Cmd_Valid = 1'b0;
    @(negedge clk);
    chk("bp_res_valid_rise", {31'd0, if1.Res_Valid}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      if1.Cmd_Valid  = i[0] ? 1'b0 : 1'b1;
      if1.Cmd_Opcode = 4'h0; if1.Cmd_A = 4'h1; if1.Cmd_B = 4'h1;
      @(negedge clk);
      chk("bp_res_valid", {31'd0, if1.Res_Valid}, 32'd1);
      chk("bp_res_data", {28'd0, if1.Res_Data}, 32'h8);
      chk("bp_res_opcode", {28'd0, if1.Res_Opcode}, 32'h8);
      chk("bp_res_zero", {31'd0, if1.Res_Zero}, 32'd0);
      chk("bp_cmd_ready", {31'd0, if1.Cmd_Ready}, 32'd0);
      chk("bp_alu_sel", {28'd0, if1.ALU_Sel}, 32'h8);
    end
    if1.Cmd_Valid = 1'b0;
    if1.Res_Ready = 1'b1;
    @(negedge clk);
    exp_cnt1 = exp_cnt1 + 8'd1;
    chk("bp_done_res_valid", {31'd0, if1.Res_Valid}, 32'd0);
    chk("bp_done_cmd_ready", {31'd0, if1.Cmd_Ready}, 32'd1);
    chk("bp_done_op_count", {24'd0, if1.Op_Count}, {24'd0, exp_cnt1});
    chk("bp_no_stray_accept", {28'd0, if1.ALU_A}, 32'hC);

    // Settle 4: capture exactly four edges after accept, operands stable
    if4.Cmd_Valid  = 1'b1;
    if4.Cmd_Opcode = 4'h0; if4.Cmd_A = 4'h6; if4.Cmd_B = 4'h7;
    @(negedge clk);
    if4.Cmd_Valid  = 1'b0;
    if4.Cmd_Opcode = 4'h5; if4.Cmd_A = 4'h2; if4.Cmd_B = 4'h3;
    for (int i = 1; i <= 4; i++) begin
      if (i < 4) chk("s4_res_valid_low", {31'd0, if4.Res_Valid}, 32'd0);
      chk("s4_alu_sel", {28'd0, if4.ALU_Sel}, 32'h0);
      chk("s4_alu_a", {28'd0, if4.ALU_A}, 32'h6);
      chk("s4_alu_b", {28'd0, if4.ALU_B}, 32'h7);
      @(negedge clk);
    end
    chk("s4_res_valid", {31'd0, if4.Res_Valid}, 32'd1);
    chk("s4_res_data", {28'd0, if4.Res_Data}, 32'hD);
    @(negedge clk);
    chk("s4_done_res_valid", {31'd0, if4.Res_Valid}, 32'd0);
    chk("s4_op_count", {24'd0, if4.Op_Count}, 32'd1);

    // 2-bit counter: back-to-back ops, one per three clocks, wrapping
    ifw.Cmd_Valid  = 1'b1;
    ifw.Cmd_Opcode = 4'h0; ifw.Cmd_A = 4'h1; ifw.Cmd_B = 4'h1;
    for (int j = 1; j <= 15; j++) begin
      @(negedge clk);
      if (j % 3 == 2) chk("wrap_res_valid", {31'd0, ifw.Res_Valid}, 32'd1);
      if (j % 3 == 0) begin
        chk("wrap_op_count", {30'd0, ifw.Op_Count}, {30'd0, wrap_exp[j / 3 - 1]});
        chk("wrap_cmd_ready", {31'd0, ifw.Cmd_Ready}, 32'd1);
      end
    end
    ifw.Cmd_Valid = 1'b0;

    // Reset mid-WAIT aborts the operation without replay
    wait_ready1();
    if1.Cmd_Valid  = 1'b1;
    if1.Cmd_Opcode = 4'h9; if1.Cmd_A = 4'h1; if1.Cmd_B = 4'h2;
    @(negedge clk);
    if1.Cmd_Valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("abort_cmd_ready", {31'd0, if1.Cmd_Ready}, 32'd0);
    chk("abort_alu_sel", {28'd0, if1.ALU_Sel}, 32'd0);
    chk("abort_res_valid", {31'd0, if1.Res_Valid}, 32'd0);
    chk("abort_op_count", {24'd0, if1.Op_Count}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_release_ready_low", {31'd0, if1.Cmd_Ready}, 32'd0);
    @(negedge clk);
    chk("abort_release_ready", {31'd0, if1.Cmd_Ready}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_no_res_valid", {31'd0, if1.Res_Valid}, 32'd0);
      chk("abort_no_replay", {28'd0, if1.ALU_Sel}, 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
